// File: rtl/wb_arbiter_stage_pkg.sv
// Shared types, default sizes and the round-robin pick helper for the
// writeback arbiter stage.
package wb_arbiter_stage_pkg;

  localparam int WB_N_CH_DEFAULT       = 3;
  localparam int WB_FIFO_DEPTH_DEFAULT = 2;
  localparam int WB_XLEN_DEFAULT       = 32;
  localparam int WB_RADDR_W_DEFAULT    = 5;

  // One buffered writeback result (default-width view; the top builds the
  // same layout from its own XLEN/RADDR_W parameters).
  typedef struct packed {
    logic                          we;
    logic [WB_RADDR_W_DEFAULT-1:0] rd_addr;
    logic [WB_XLEN_DEFAULT-1:0]    rd;
  } wb_entry_t;

  // Round-robin pick over up to 8 requesters, starting at ptr_i and wrapping
  // modulo n_i. Returns {found, index}; the lowest offset from ptr_i wins.
  function automatic logic [3:0] wb_rr_pick(input logic [7:0] req_i,
                                            input logic [2:0] ptr_i,
                                            input logic [3:0] n_i);
    logic [3:0] res;
    logic [3:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = {1'b0, ptr_i} + 4'(i);
      if (idx >= n_i) begin
        idx = idx - n_i;
      end else begin
        idx = idx;
      end
      if ((4'(i) < n_i) && req_i[idx[2:0]]) begin
        res = {1'b1, idx[2:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/wb_arbiter_stage_ch_fifo.sv
// wb_ch_fifo: one per-channel result FIFO with push, pop, flush and an
// occupancy count. A push into a full FIFO is ignored, as is any push or pop
// in a flush cycle.
module wb_ch_fifo
  import wb_arbiter_stage_pkg::*;
#(
  parameter int  DEPTH   = WB_FIFO_DEPTH_DEFAULT,
  parameter type entry_t = wb_entry_t,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  input  logic          push_i,
  input  entry_t        push_data_i,
  input  logic          pop_i,
  output entry_t        head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_s, push_s, pop_s;

  assign full_s  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == CW'(0));
  assign push_s  = push_i & ~full_s & ~flush_i;
  assign pop_s   = pop_i & ~empty_o & ~flush_i;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointers/occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = AW'(0);
      rd_ptr_d = AW'(0);
      count_d  = CW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Payload storage; validity is tracked by count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (rst && push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wb_arbiter_stage.sv
// wb_arbiter_stage: merges N_CH buffered result channels into one registered
// register-file write port plus bypass bus, round-robin, one entry per cycle.
// Optional feature: define WB_RETIRE_CNT_EN to build the 64-bit retire
// counter; otherwise retire_cnt_o is tied to zero.
module wb_arbiter_stage
  import wb_arbiter_stage_pkg::*;
#(
  parameter int N_CH       = WB_N_CH_DEFAULT,
  parameter int XLEN       = WB_XLEN_DEFAULT,
  parameter int RADDR_W    = WB_RADDR_W_DEFAULT,
  parameter int FIFO_DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CH-1:0]               ch_valid_i,
  output logic [N_CH-1:0]               ch_ready_o,
  input  logic [N_CH-1:0]               ch_we_i,
  input  logic [N_CH-1:0][RADDR_W-1:0]  ch_rd_addr_i,
  input  logic [N_CH-1:0][XLEN-1:0]     ch_rd_i,
  input  logic                          flush_i,
  input  logic                          stall_i,
  output logic                          rf_we_o,
  output logic [RADDR_W-1:0]            rf_waddr_o,
  output logic [XLEN-1:0]               rf_wdata_o,
  output logic [RADDR_W-1:0]            bp_rd_addr_o,
  output logic [XLEN-1:0]               bp_rd_o,
  output logic                          unstall_o,
  output logic [63:0]                   retire_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic               we;
    logic [RADDR_W-1:0] rd_addr;
    logic [XLEN-1:0]    rd;
  } entry_t;

  entry_t                  head_s [N_CH];
  entry_t                  sel_s;
  logic [N_CH-1:0][CW-1:0] count_s;
  logic [N_CH-1:0]         empty_s, push_s, pop_s;
  logic [7:0]              req_s;
  logic [3:0]              pick_s;
  logic                    grant_s;
  logic [2:0]              grant_idx_s;
  logic [2:0]              rr_ptr_q, rr_ptr_d;
  logic                    rf_we_q, rf_we_d;
  logic [RADDR_W-1:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]         rf_wdata_q, rf_wdata_d;
  logic                    unstall_q;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    entry_t push_data_s;
    assign push_data_s   = {ch_we_i[c], ch_rd_addr_i[c], ch_rd_i[c]};
    // No pass-through: a full FIFO stays not-ready even while it is popped.
    assign ch_ready_o[c] = rst & (count_s[c] < CW'(FIFO_DEPTH));
    assign push_s[c]     = ch_valid_i[c] & ch_ready_o[c];
    assign pop_s[c]      = grant_s & (grant_idx_s == 3'(c));

    wb_ch_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .push_i      (push_s[c]),
      .push_data_i (push_data_s),
      .pop_i       (pop_s[c]),
      .head_o      (head_s[c]),
      .count_o     (count_s[c]),
      .empty_o     (empty_s[c])
    );
  end

  // Round-robin grant among non-empty FIFOs; a flush cycle pops nothing.
  always_comb begin
    req_s            = 8'd0;
    req_s[N_CH-1:0]  = ~empty_s;
    pick_s           = wb_rr_pick(req_s, rr_ptr_q, 4'(N_CH));
    grant_s          = pick_s[3] & ~flush_i;
    grant_idx_s      = pick_s[2:0];
  end

  // Mux the granted FIFO head.
  always_comb begin
    sel_s = {($bits(entry_t)){1'b0}};
    for (int c = 0; c < N_CH; c++) begin
      if (pop_s[c]) begin
        sel_s = head_s[c];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Next pointer and write-port values; x0 and retire-only entries drive zeros.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = {RADDR_W{1'b0}};
    rf_wdata_d = {XLEN{1'b0}};
    if (flush_i) begin
      rr_ptr_d = 3'd0;
    end else if (grant_s) begin
      rr_ptr_d = (grant_idx_s == 3'(N_CH - 1)) ? 3'd0 : grant_idx_s + 3'd1;
      if (sel_s.we && (sel_s.rd_addr != {RADDR_W{1'b0}})) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = sel_s.rd_addr;
        rf_wdata_d = sel_s.rd;
      end else begin
        rf_we_d    = 1'b0;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Arbiter pointer, registered write port and one-cycle stall echo.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr_q   <= 3'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= {RADDR_W{1'b0}};
      rf_wdata_q <= {XLEN{1'b0}};
      unstall_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      unstall_q  <= stall_i;
    end
  end

  assign rf_we_o      = rf_we_q;
  assign rf_waddr_o   = rf_waddr_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign bp_rd_addr_o = rf_waddr_q;
  assign bp_rd_o      = rf_wdata_q;
  assign unstall_o    = unstall_q;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q;

  // Counts every popped entry; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt_q <= 64'd0;
    end else if (grant_s) begin
      retire_cnt_q <= retire_cnt_q + 64'd1;
    end else begin
      retire_cnt_q <= retire_cnt_q;
    end
  end

  assign retire_cnt_o = retire_cnt_q;
`else
  assign retire_cnt_o = 64'd0;
`endif

endmodule

// File: tb/tb_wb_arbiter_stage.sv
// Self-checking bench for wb_arbiter_stage: queue-based reference model,
// per-cycle compare process, directed literal checks, then random traffic.
module tb_wb_arbiter_stage;

  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       ch_valid_i, ch_ready_o, ch_we_i;
  logic [2:0][4:0]  ch_rd_addr_i;
  logic [2:0][31:0] ch_rd_i;
  logic             flush_i, stall_i;
  logic             rf_we_o, unstall_o;
  logic [4:0]       rf_waddr_o, bp_rd_addr_o;
  logic [31:0]      rf_wdata_o, bp_rd_o;
  logic [63:0]      retire_cnt_o;

  wb_arbiter_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ch_valid_i   (ch_valid_i),
    .ch_ready_o   (ch_ready_o),
    .ch_we_i      (ch_we_i),
    .ch_rd_addr_i (ch_rd_addr_i),
    .ch_rd_i      (ch_rd_i),
    .flush_i      (flush_i),
    .stall_i      (stall_i),
    .rf_we_o      (rf_we_o),
    .rf_waddr_o   (rf_waddr_o),
    .rf_wdata_o   (rf_wdata_o),
    .bp_rd_addr_o (bp_rd_addr_o),
    .bp_rd_o      (bp_rd_o),
    .unstall_o    (unstall_o),
    .retire_cnt_o (retire_cnt_o)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit        we;
    bit [4:0]  a;
    bit [31:0] d;
  } ent_t;

  ent_t            mq [3][$];
  int              m_ptr;
  bit              e_we, e_unstall;
  bit [4:0]        e_addr;
  bit [31:0]       e_data;
  longint unsigned e_cnt;

  always @(posedge clk) begin
    bit [2:0] rdy;
    int       g;
    int       c;
    ent_t     e;
    ent_t     n;
    if (!rst) begin
      for (int k = 0; k < 3; k++) mq[k].delete();
      m_ptr = 0; e_we = 0; e_addr = 0; e_data = 0; e_unstall = 0; e_cnt = 0;
    end else begin
      for (int k = 0; k < 3; k++) rdy[k] = (mq[k].size() < DEPTH);
      e_unstall = stall_i;
      e_we = 0; e_addr = 0; e_data = 0;
      if (flush_i) begin
        for (int k = 0; k < 3; k++) mq[k].delete();
        m_ptr = 0;
      end else begin
        g = -1;
        for (int i = 0; i < 3; i++) begin
          c = (m_ptr + i) % 3;
          if (g < 0 && mq[c].size() > 0) g = c;
        end
        if (g >= 0) begin
          e = mq[g].pop_front();
          m_ptr = (g + 1) % 3;
          e_cnt++;
          if (e.we && e.a != 5'd0) begin
            e_we = 1; e_addr = e.a; e_data = e.d;
          end
        end
        for (int k = 0; k < 3; k++) begin
          if (ch_valid_i[k] && rdy[k]) begin
            n.we = ch_we_i[k]; n.a = ch_rd_addr_i[k]; n.d = ch_rd_i[k];
            mq[k].push_back(n);
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [2:0]  er;
    logic [63:0] ec;
    if (chk_en) begin
      for (int k = 0; k < 3; k++) er[k] = rst && (mq[k].size() < DEPTH);
`ifdef WB_RETIRE_CNT_EN
      ec = e_cnt;
`else
      ec = 64'd0;
`endif
      chk("m_ready",   ch_ready_o,   er);
      chk("m_we",      rf_we_o,      e_we);
      chk("m_waddr",   rf_waddr_o,   e_addr);
      chk("m_wdata",   rf_wdata_o,   e_data);
      chk("m_bpaddr",  bp_rd_addr_o, e_addr);
      chk("m_bpdata",  bp_rd_o,      e_data);
      chk("m_unstall", unstall_o,    e_unstall);
      chk("m_retire",  retire_cnt_o, ec);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ch_valid_i = 3'b000; ch_we_i = 3'b000; flush_i = 1'b0; stall_i = 1'b0;
    ch_rd_addr_i = '0; ch_rd_i = '0;
  endtask

  logic [4:0]  rr_exp [6];
  logic [63:0] cnt_exp;

  initial begin
    rr_exp = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3};
`ifdef WB_RETIRE_CNT_EN
    cnt_exp = 64'd4;
`else
    cnt_exp = 64'd0;
`endif
    idle_in();
    rst = 1'b0; ch_valid_i = 3'b111; ch_we_i = 3'b111;

    // Reset: two edges with valid asserted, nothing may be stored.
    step(); chk_en = 1'b1;
    @(negedge clk); chk("rst_ready", ch_ready_o, 3'b000); chk("rst_we", rf_we_o, 1'b0);
    step(); rst = 1'b1; idle_in();
    step(); @(negedge clk); chk("rst_nostore_a", rf_we_o, 1'b0);
    step(); @(negedge clk); chk("rst_nostore_b", rf_we_o, 1'b0);
    chk("rst_ready_after", ch_ready_o, 3'b111);

    // Single write: push in cycle k, visible in k+2.
    step(); ch_valid_i = 3'b001; ch_we_i = 3'b001;
    ch_rd_addr_i[0] = 5'd5; ch_rd_i[0] = 32'hDEADBEEF;
    step(); idle_in();
    step(); @(negedge clk);
    chk("single_we", rf_we_o, 1'b1); chk("single_waddr", rf_waddr_o, 5'd5);
    chk("single_wdata", rf_wdata_o, 32'hDEADBEEF); chk("single_bp", bp_rd_o, 32'hDEADBEEF);

    // Three more retirements (pointer now at ch1): ch1 we=0, ch2 rd=9, ch0 rd=10.
    step(); ch_valid_i = 3'b111; ch_we_i = 3'b101;
    ch_rd_addr_i[0] = 5'd10; ch_rd_addr_i[1] = 5'd3; ch_rd_addr_i[2] = 5'd9;
    ch_rd_i[0] = 32'h100; ch_rd_i[1] = 32'h101; ch_rd_i[2] = 32'h102;
    step(); idle_in();
    step(); @(negedge clk); chk("retire_only_we", rf_we_o, 1'b0);
    step(); @(negedge clk); chk("rr_after_ch1", rf_waddr_o, 5'd9);
    step(); @(negedge clk); chk("rr_after_ch2", rf_waddr_o, 5'd10);
    step(); step(); @(negedge clk); chk("retire_cnt4", retire_cnt_o, cnt_exp);

    // Unstall echo.
    step(); stall_i = 1'b1; @(negedge clk); chk("unstall_pre", unstall_o, 1'b0);
    step(); stall_i = 1'b0; @(negedge clk); chk("unstall_pulse", unstall_o, 1'b1);
    step(); @(negedge clk); chk("unstall_post", unstall_o, 1'b0);

    // Round robin from pointer 0 (flush resets it), all channels every cycle.
    step(); flush_i = 1'b1;
    step(); flush_i = 1'b0; ch_valid_i = 3'b111; ch_we_i = 3'b111;
    ch_rd_addr_i[0] = 5'd1; ch_rd_addr_i[1] = 5'd2; ch_rd_addr_i[2] = 5'd3;
    step();
    for (int i = 0; i < 6; i++) begin
      step(); @(negedge clk);
      chk("rr_we", rf_we_o, 1'b1); chk("rr_waddr", rf_waddr_o, rr_exp[i]);
    end
    idle_in(); repeat (8) step();

    // Full + x0: ch1 gets two entries (second to x0) and is then not ready.
    flush_i = 1'b1;
    step(); flush_i = 1'b0; ch_valid_i = 3'b111; ch_we_i = 3'b111;
    ch_rd_addr_i[0] = 5'd11; ch_rd_addr_i[1] = 5'd7; ch_rd_addr_i[2] = 5'd12;
    step(); ch_rd_addr_i[1] = 5'd0;
    step(); ch_valid_i = 3'b010; @(negedge clk); chk("full_ready", ch_ready_o, 3'b001);
    step(); idle_in(); repeat (8) step();
    ch_valid_i = 3'b100; ch_we_i = 3'b100; ch_rd_addr_i[2] = 5'd0; ch_rd_i[2] = 32'hFFFFFFFF;
    step(); idle_in();
    step(); @(negedge clk);
    chk("x0_we", rf_we_o, 1'b0); chk("x0_wdata", rf_wdata_o, 32'h0); chk("x0_bpaddr", bp_rd_addr_o, 5'd0);

    // Flush with two buffered entries and a same-cycle push.
    step(); ch_valid_i = 3'b011; ch_we_i = 3'b011;
    ch_rd_addr_i[0] = 5'd4; ch_rd_addr_i[1] = 5'd6;
    step(); flush_i = 1'b1; ch_valid_i = 3'b100; ch_we_i = 3'b100; ch_rd_addr_i[2] = 5'd8;
    step(); idle_in(); @(negedge clk);
    chk("flush_we", rf_we_o, 1'b0); chk("flush_ready", ch_ready_o, 3'b111);
    step(); @(negedge clk); chk("flush_drop_a", rf_we_o, 1'b0);
    step(); @(negedge clk); chk("flush_drop_b", rf_we_o, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      rst     = ($urandom_range(0, 299) != 0);
      flush_i = ($urandom_range(0, 39) == 0);
      stall_i = $urandom_range(0, 1);
      for (int c = 0; c < 3; c++) begin
        ch_valid_i[c]   = ($urandom_range(0, 2) != 0);
        ch_we_i[c]      = ($urandom_range(0, 5) != 0);
        ch_rd_addr_i[c] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
        ch_rd_i[c]      = $urandom;
      end
    end
    step(); rst = 1'b1; idle_in();
    repeat (4) step();
    @(negedge clk);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
